poly_note_control: RTL and testbench



---
 rtl/poly_note_control.sv | 139 +++++++++++++
 tb/tb_poly_note_control.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/poly_note_control.sv
// Polyphonic note controller: assigns validated UART note codes to voice slots,
// each held for a fixed number of millisecond ticks before release.
module poly_note_control #(
  parameter int C_CLK_FRQ         = 100_000_000,
  parameter int C_MUSIC           = 500,
  parameter int C_UART_DATA_WIDTH = 8,
  parameter int C_CHANNELS        = 4
) (
  input  logic                                    clk,
  input  logic                                    rstb,
  input  logic                                    UART_err,
  input  logic                                    UART_valid,
  input  logic [C_UART_DATA_WIDTH-1:0]            UART_msg,
  output logic [C_CHANNELS*C_UART_DATA_WIDTH-1:0] outNotes,
  output logic [C_CHANNELS-1:0]                   outActive,
  output logic                                    outErr
);

  localparam int W  = C_UART_DATA_WIDTH;
  localparam int P  = C_CLK_FRQ / 1000;
  localparam int PW = (P > 1) ? $clog2(P) : 1;
  localparam int RW = $clog2(C_MUSIC + 1);
  localparam int CW = (C_CHANNELS > 1) ? $clog2(C_CHANNELS) : 1;

  typedef enum logic {sIdle, sPlay} state_t;

  state_t         state     [C_CHANNELS];
  logic [W-1:0]   note      [C_CHANNELS];
  logic [RW-1:0]  remaining [C_CHANNELS];
  logic [PW-1:0]  presc;
  logic           tick;

  logic           cmd;
  logic           all_off;
  logic           note_cmd;
  logic           hit;
  logic           free;
  logic [CW-1:0]  hit_idx;
  logic [CW-1:0]  free_idx;
  logic [CW-1:0]  steal_idx;
  logic [CW-1:0]  load_idx;
  logic [RW-1:0]  best_rem;

  // Millisecond prescaler, free-running from reset.
  assign tick = (presc == PW'(P - 1));

  always_ff @(posedge clk) begin
    if (!rstb) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign cmd      = UART_valid && !UART_err;
  assign all_off  = cmd && (UART_msg == '0);
  assign note_cmd = cmd && (UART_msg != '0);

  // Slot choice priority: retrigger match, then lowest idle slot, then the
  // active slot closest to expiry (strict < keeps the lowest index on ties).
  always_comb begin
    hit       = 1'b0;
    free      = 1'b0;
    hit_idx   = '0;
    free_idx  = '0;
    steal_idx = '0;
    best_rem  = remaining[0];
    for (int k = 0; k < C_CHANNELS; k++) begin
      if (!hit && state[k] == sPlay && note[k] == UART_msg) begin
        hit     = 1'b1;
        hit_idx = CW'(k);
      end
      if (!free && state[k] == sIdle) begin
        free     = 1'b1;
        free_idx = CW'(k);
      end
    end
    for (int k = 1; k < C_CHANNELS; k++) begin
      if (remaining[k] < best_rem) begin
        best_rem  = remaining[k];
        steal_idx = CW'(k);
      end
    end
    if (hit) begin
      load_idx = hit_idx;
    end else if (free) begin
      load_idx = free_idx;
    end else begin
      load_idx = steal_idx;
    end
  end

  // A load in a tick cycle takes precedence over the countdown of that slot.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      outErr <= 1'b0;
      for (int k = 0; k < C_CHANNELS; k++) begin
        state[k]     <= sIdle;
        note[k]      <= '0;
        remaining[k] <= '0;
      end
    end else begin
      outErr <= UART_valid && UART_err;
      for (int k = 0; k < C_CHANNELS; k++) begin
        if (all_off) begin
          state[k]     <= sIdle;
          note[k]      <= '0;
          remaining[k] <= '0;
        end else if (note_cmd && load_idx == CW'(k)) begin
          remaining[k] <= RW'(C_MUSIC);
          if (!hit) begin
            note[k]  <= UART_msg;
            state[k] <= sPlay;
          end
        end else if (tick && state[k] == sPlay) begin
          if (remaining[k] > RW'(1)) begin
            remaining[k] <= remaining[k] - 1'b1;
          end else begin
            state[k]     <= sIdle;
            note[k]      <= '0;
            remaining[k] <= '0;
          end
        end
      end
    end
  end

  always_comb begin
    outNotes  = '0;
    outActive = '0;
    for (int k = 0; k < C_CHANNELS; k++) begin
      outNotes[k*W +: W] = note[k];
      outActive[k]       = (state[k] == sPlay);
    end
  end

endmodule

// File: tb/tb_poly_note_control.sv
// Directed bench for poly_note_control with P=10 and a 3 ms note duration.
module tb_poly_note_control;

  logic        clk;
  logic        rstb;
  logic        UART_err;
  logic        UART_valid;
  logic [7:0]  UART_msg;
  logic [31:0] outNotes;
  logic [3:0]  outActive;
  logic        outErr;

  int cyc;
  int errors;
  int checks;

  typedef struct {
    bit          rst;
    int          cyc;
    bit          valid;
    bit          err;
    logic [7:0]  msg;
    logic [3:0]  active;
    logic [31:0] notes;
    bit          errOut;
    string       name;
  } vec_t;

  vec_t vecs[$];

  poly_note_control #(
    .C_CLK_FRQ(10_000),
    .C_MUSIC(3),
    .C_UART_DATA_WIDTH(8),
    .C_CHANNELS(4)
  ) dut (
    .clk(clk),
    .rstb(rstb),
    .UART_err(UART_err),
    .UART_valid(UART_valid),
    .UART_msg(UART_msg),
    .outNotes(outNotes),
    .outActive(outActive),
    .outErr(outErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic gotoCycle(input int n);
    while (cyc < n) step();
  endtask

  // The last posedge sampling rstb=0 is cycle 0.
  task automatic doReset();
    rstb = 1'b0;
    UART_valid = 1'b0;
    UART_err = 1'b0;
    UART_msg = 8'h00;
    @(posedge clk);
    @(posedge clk);
    #1;
    rstb = 1'b1;
    cyc = 0;
  endtask

  task automatic applyStimulus(input bit valid, input bit err, input logic [7:0] msg);
    UART_valid = valid;
    UART_err = err;
    UART_msg = msg;
    step();
    UART_valid = 1'b0;
    UART_err = 1'b0;
    UART_msg = 8'h00;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] active,
                             input logic [31:0] notes, input bit errOut);
    checks++;
    if ({outActive, outNotes, outErr} !== {active, notes, errOut}) begin
      errors++;
      $display("[TB] FAIL %s @cycle %0d: got active=%b notes=%h err=%b, want active=%b notes=%h err=%b",
               name, cyc, outActive, outNotes, outErr, active, notes, errOut);
    end
  endtask

  task automatic addVec(input bit rst, input int c, input bit valid, input bit err,
                        input logic [7:0] msg, input logic [3:0] active,
                        input logic [31:0] notes, input bit errOut, input string name);
    vec_t v;
    v.rst = rst; v.cyc = c; v.valid = valid; v.err = err; v.msg = msg;
    v.active = active; v.notes = notes; v.errOut = errOut; v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc = 0;
    rstb = 1'b0;
    UART_valid = 1'b0;
    UART_err = 1'b0;
    UART_msg = 8'h00;

    // Each row drives its inputs during cycle .cyc and checks at .cyc+1.
    addVec(1,  2, 1, 0, 8'h3C, 4'b0001, 32'h0000003C, 0, "single_alloc");
    addVec(0, 28, 0, 0, 8'h00, 4'b0001, 32'h0000003C, 0, "single_hold");
    addVec(0, 29, 0, 0, 8'h00, 4'b0000, 32'h00000000, 0, "single_expire");
    addVec(1,  2, 1, 0, 8'h10, 4'b0001, 32'h00000010, 0, "fill_ch0");
    addVec(0,  4, 1, 0, 8'h11, 4'b0011, 32'h00001110, 0, "fill_ch1");
    addVec(0,  6, 1, 0, 8'h12, 4'b0111, 32'h00121110, 0, "fill_ch2");
    addVec(0,  8, 1, 0, 8'h13, 4'b1111, 32'h13121110, 0, "fill_ch3");
    addVec(0, 12, 1, 0, 8'h14, 4'b1111, 32'h13121114, 0, "steal_tie");
    addVec(0, 14, 1, 0, 8'h15, 4'b1111, 32'h13121514, 0, "steal_min");
    addVec(0, 29, 1, 0, 8'h16, 4'b0111, 32'h00161514, 0, "steal_expiring");
    addVec(0, 39, 0, 0, 8'h00, 4'b0100, 32'h00160000, 0, "expire_pair");
    addVec(0, 58, 0, 0, 8'h00, 4'b0100, 32'h00160000, 0, "stolen_hold");
    addVec(0, 59, 0, 0, 8'h00, 4'b0000, 32'h00000000, 0, "stolen_expire");
    addVec(1,  2, 1, 0, 8'h21, 4'b0001, 32'h00000021, 0, "eo_ch0");
    addVec(0,  4, 1, 0, 8'h22, 4'b0011, 32'h00002221, 0, "eo_ch1");
    addVec(0,  6, 1, 1, 8'h55, 4'b0011, 32'h00002221, 1, "err_pulse");
    addVec(0,  7, 0, 0, 8'h00, 4'b0011, 32'h00002221, 0, "err_one_cycle");
    addVec(0,  8, 1, 1, 8'h00, 4'b0011, 32'h00002221, 1, "err_zero_ignored");
    addVec(0,  9, 1, 0, 8'h00, 4'b0000, 32'h00000000, 0, "all_off");

    foreach (vecs[i]) begin
      if (vecs[i].rst) begin
        doReset();
        checkOutput("reset_state", 4'b0000, 32'h0, 1'b0);
      end
      gotoCycle(vecs[i].cyc);
      applyStimulus(vecs[i].valid, vecs[i].err, vecs[i].msg);
      checkOutput(vecs[i].name, vecs[i].active, vecs[i].notes, vecs[i].errOut);
    end

    // Retrigger restarts the duration without taking a second slot.
    doReset();
    gotoCycle(2);
    applyStimulus(1, 0, 8'h3C);
    gotoCycle(25);
    applyStimulus(1, 0, 8'h3C);
    checkOutput("retrig_same_slot", 4'b0001, 32'h0000003C, 0);
    gotoCycle(30);
    checkOutput("retrig_extended", 4'b0001, 32'h0000003C, 0);
    gotoCycle(49);
    checkOutput("retrig_hold", 4'b0001, 32'h0000003C, 0);
    step();
    checkOutput("retrig_expire", 4'b0000, 32'h0, 0);

    // Load in a tick cycle keeps the full duration.
    doReset();
    gotoCycle(9);
    applyStimulus(1, 0, 8'h20);
    checkOutput("collide_load", 4'b0001, 32'h00000020, 0);
    gotoCycle(39);
    checkOutput("collide_hold", 4'b0001, 32'h00000020, 0);
    step();
    checkOutput("collide_expire", 4'b0000, 32'h0, 0);

    // Mid-note reset clears everything and restarts the prescaler.
    doReset();
    gotoCycle(2);
    applyStimulus(1, 0, 8'h31);
    applyStimulus(1, 0, 8'h32);
    applyStimulus(1, 0, 8'h33);
    checkOutput("pre_reset_three", 4'b0111, 32'h00333231, 0);
    gotoCycle(6);
    rstb = 1'b0;
    UART_valid = 1'b1;
    UART_msg = 8'h44;
    step();
    rstb = 1'b1;
    UART_valid = 1'b0;
    UART_msg = 8'h00;
    checkOutput("mid_reset_clear", 4'b0000, 32'h0, 0);
    applyStimulus(1, 0, 8'h40);
    checkOutput("post_reset_alloc", 4'b0001, 32'h00000040, 0);
    gotoCycle(36);
    checkOutput("post_reset_hold", 4'b0001, 32'h00000040, 0);
    step();
    checkOutput("post_reset_expire", 4'b0000, 32'h0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
